// File: rtl/ps2_receiver_if.sv
// rtl/ps2_receiver_if.sv - PS/2 line inputs and decoded scan-code outputs
interface ps2_receiver_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ps2_data;
    logic       ps2_hit;
    logic       ps2_err;

    modport master (output ps2_clk, ps2_dat, input ps2_data, ps2_hit, ps2_err);
    modport slave  (input ps2_clk, ps2_dat, output ps2_data, ps2_hit, ps2_err);
endinterface

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 frame deserialiser with sync, clock filter, parity/stop check, timeout
module ps2_receiver #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic            clock,
    input  logic            reset_n,
    ps2_receiver_if.slave   bus
);
    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          kclk_s;
    logic          kdat_s;
    logic [FW-1:0] fcnt;
    logic          kclk_f;
    logic          kclk_f_q;
    logic          fall;

    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tcnt;

    assign kclk_s = clk_sync[1];
    assign kdat_s = dat_sync[1];
    assign fall   = kclk_f_q & ~kclk_f;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], bus.ps2_clk};
            dat_sync <= {dat_sync[0], bus.ps2_dat};
        end
    end

    // A level change is accepted only after FILTER consecutive disagreeing samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt     <= '0;
            kclk_f   <= 1'b1;
            kclk_f_q <= 1'b1;
        end else begin
            kclk_f_q <= kclk_f;
            if (kclk_s == kclk_f) begin
                fcnt <= '0;
            end else if (fcnt == FILTER_LAST) begin
                fcnt   <= '0;
                kclk_f <= kclk_s;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shift        <= '0;
            par          <= 1'b0;
            tcnt         <= '0;
            bus.ps2_data <= 8'h00;
            bus.ps2_hit  <= 1'b0;
            bus.ps2_err  <= 1'b0;
        end else begin
            bus.ps2_hit <= 1'b0;
            bus.ps2_err <= 1'b0;
            if (state == IDLE) begin
                tcnt <= '0;
                if (fall && !kdat_s) begin
                    state  <= DATA;
                    bitcnt <= '0;
                end
            end else if (fall) begin
                // A fall always beats a coincident timeout.
                tcnt <= '0;
                case (state)
                    DATA: begin
                        shift  <= {kdat_s, shift[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= kdat_s;
                        state <= STOP;
                    end
                    default: begin
                        if (kdat_s && (^{shift, par})) begin
                            bus.ps2_data <= shift;
                            bus.ps2_hit  <= 1'b1;
                        end else begin
                            bus.ps2_err  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (tcnt == TIMEOUT_LAST) begin
                tcnt        <= '0;
                state       <= IDLE;
                bus.ps2_err <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - scoreboard bench for ps2_receiver with randomized frames
module tb_ps2_receiver;
    localparam int HALF = 200;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clock;
    logic reset_n;
    ps2_receiver_if bus();

    ps2_receiver #(.FILTER(8), .TIMEOUT(2000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_last = 8'h00;

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.ps2_hit && bus.ps2_err) begin
                checks++;
                errors++;
                $display("FAIL hit_err_both got hit=1 err=1 want at most one");
            end else if (bus.ps2_hit || bus.ps2_err) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse got hit=%0b err=%0b data=%02h want none",
                             bus.ps2_hit, bus.ps2_err, bus.ps2_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.ps2_err != e.err) begin
                        errors++;
                        $display("FAIL pulse_kind got err=%0b want err=%0b", bus.ps2_err, e.err);
                    end else if (bus.ps2_hit && bus.ps2_data != e.data) begin
                        errors++;
                        $display("FAIL hit_data got %02h want %02h", bus.ps2_data, e.data);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Reference: a frame is good when the stop bit is 1 and data+parity hold an odd number of ones.
    task automatic expect_frame(input logic [7:0] data, input logic par, input logic stop);
        int ones;
        exp_t e;
        ones = par;
        for (int i = 0; i < 8; i++) ones += data[i];
        if (stop && (ones % 2 == 1)) begin
            e.err = 1'b0;
            e.data = data;
            exp_last = data;
        end else begin
            e.err = 1'b1;
            e.data = 8'h00;
        end
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        bus.ps2_dat = 1'($urandom_range(0, 1));
        if (glitch) begin
            cycles(30);
            bus.ps2_clk = 1'b0;
            cycles($urandom_range(1, 7));
            bus.ps2_clk = 1'b1;
            cycles(70);
        end else begin
            cycles(100);
        end
        bus.ps2_dat = b;
        cycles(HALF - 100);
        bus.ps2_clk = 1'b0;
        cycles(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int nbits, input logic glitchy);
        logic [10:0] f;
        f = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++)
            send_bit(f[i], glitchy && ($urandom_range(0, 3) == 0));
        bus.ps2_dat = 1'b1;
    endtask

    task automatic frame_done(input string name);
        check({name, "_drained"}, q.size(), 0);
        check({name, "_data"}, bus.ps2_data, exp_last);
    endtask

    task automatic good_frame(input logic [7:0] data, input string name);
        expect_frame(data, ~^data, 1'b1);
        send_frame(data, ~^data, 1'b1, 11, 1'b0);
        frame_done(name);
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        cycles(5);
        #1;
        check("reset_data", bus.ps2_data, 8'h00);
        check("reset_hit", bus.ps2_hit, 1'b0);
        check("reset_err", bus.ps2_err, 1'b0);
        reset_n = 1'b1;
        cycles(20);

        good_frame(8'h1C, "f1c");
        expect_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        check("b2b_first", bus.ps2_data, 8'hF0);
        good_frame(8'h1C, "b2b_second");

        expect_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        frame_done("bad_parity");

        expect_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, 11, 1'b0);
        frame_done("bad_stop");

        bus.ps2_clk = 1'b0;
        cycles(3);
        bus.ps2_clk = 1'b1;
        cycles(100);
        frame_done("idle_glitch");

        q.push_back('{err: 1'b1, data: 8'h00});
        send_frame(8'h5A, 1'b1, 1'b1, 6, 1'b0);
        cycles(2500);
        frame_done("timeout");
        good_frame(8'h12, "after_timeout");

        send_frame(8'hA5, 1'b1, 1'b1, 4, 1'b0);
        cycles(50);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_data", bus.ps2_data, 8'h00);
        check("async_rst_hit", bus.ps2_hit, 1'b0);
        check("async_rst_err", bus.ps2_err, 1'b0);
        exp_last = 8'h00;
        cycles(20);
        reset_n = 1'b1;
        cycles(20);
        good_frame(8'h5A, "after_reset");

        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom_range(0, 255));
            p = ($urandom_range(0, 3) == 0) ? ^d : ~^d;
            s = ($urandom_range(0, 7) != 0);
            expect_frame(d, p, s);
            send_frame(d, p, s, 11, 1'b1);
            if ($urandom_range(0, 1) == 1) cycles($urandom_range(1, 300));
            frame_done("random");
        end

        cycles(50);
        check("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
